cache_fill_ctl: RTL and testbench
=================================

# cache_fill_ctl

Cache read/fill sequencer that sits directly upstream of the cache data path. It accepts microcode read requests and presents the physical address on `pad_h`. It samples the hit and parity results one cycle later. On a miss or parity error it runs a memory read and writes the returned longword into the cache. It also runs a full-cache invalidate sweep on request.

## Interface
- `FLUSH_LINES`, default 1024. Number of cache indices swept by a flush; the index counter is 10 bits.
- `b_clk_l` in 1: system clock. All registers update on its rising edge.
- `reset_h` in 1: reset. Asynchronous, active-high.
- `rd_req_h` in 1: read request. Sampled only in IDLE.
- `pa_h` in 24: physical address of the read request.
- `flush_req_h` in 1: invalidate-all request. Pulse or level.
- `ca_hit_h` in 1: hit result from the data path.
- `ca_tag_par_err_h` in 1: tag parity error from the data path.
- `ca_data_par_err_l` in 1: data parity error from the data path, active-low.
- `cache_out_h` in 32: read data from the data path.
- `mem_ack_h` in 1: memory data valid.
- `mem_err_h` in 1: memory error, qualified by `mem_ack_h`.
- `mem_data_h` in 32: memory read data.
- `pad_h` out 24: address to the data path.
- `cache_h` out 32: write data to the data path.
- `cache_grp0_wr_h` out 1: cache write strobe.
- `cache_valid_0_h` out 1: valid bit written with the tag.
- `ena_byte_l` out 4: byte write enables, active-low.
- `ca_hit_inh_h` out 1: hit inhibit.
- `mem_req_h` out 1: memory read request.
- `mem_addr_h` out 24: memory read address.
- `rd_data_h` out 32: read result.
- `rd_done_h` out 1: one-cycle completion pulse.
- `rd_err_h` out 1: error flag, valid with `rd_done_h`.
- `busy_h` out 1: block is not idle.
- `ca_perr_h` out 1: sticky parity-error flag. Cleared only by reset.

## Operation
- States: IDLE, LOOKUP, MREQ, MWAIT, FILL, FLUSH.
- IDLE:
  - If `flush_req_h` is set, go to FLUSH with index = 0. Flush has priority over `rd_req_h` in the same cycle.
  - Else if `rd_req_h` is set, latch `pa_h` into the address register and go to LOOKUP.
- LOOKUP: sample `ca_hit_h`, `ca_tag_par_err_h` and `ca_data_par_err_l`.
  - Hit with no parity error: `rd_data_h` ← `cache_out_h`, pulse `rd_done_h`, go to IDLE.
  - Any parity error: set `ca_perr_h` and treat as a miss.
  - Miss: go to MREQ.
- MREQ: assert `mem_req_h` with `mem_addr_h` = latched address, go to MWAIT.
- MWAIT: hold `mem_req_h` high until `mem_ack_h`.
  - On ack: latch `mem_data_h` and `mem_err_h`, deassert `mem_req_h` in the same cycle, go to FILL.
- FILL: one cycle.
  - Drive `cache_grp0_wr_h` = 1, `ena_byte_l` = 4'b0000, `cache_h` = latched data, `cache_valid_0_h` = ~latched error.
  - Pulse `rd_done_h`, with `rd_data_h` = latched data and `rd_err_h` = latched error. Go to IDLE.
- FLUSH: each cycle:
  - `pad_h[11:2]` = index, `pad_h[23:12]` = 0, `pad_h[1:0]` = 0.
  - `cache_grp0_wr_h` = 1, `cache_valid_0_h` = 0, `ena_byte_l` = 4'b1111 (tag-only write).
  - index increments; at index = `FLUSH_LINES`-1, go to IDLE next cycle. Exactly `FLUSH_LINES` write cycles.
- Outside FLUSH, `pad_h` = latched address. `ca_hit_inh_h` = 1 in every state except LOOKUP.
- `flush_req_h` arriving during a read is remembered in a pending bit. The flush starts from IDLE after the read completes; the pending bit clears on flush entry.
- `rd_req_h` outside IDLE is ignored. The requester holds it until `rd_done_h`; a request still high in the IDLE cycle after `rd_done_h` starts a new read.

## Timing
- Reset values: state IDLE, all outputs 0 except `ena_byte_l` = 4'b1111 and `ca_hit_inh_h` = 1. Pending flush, `ca_perr_h` and index all 0.
- Hit latency: request in IDLE at cycle 0, LOOKUP at cycle 1, `rd_done_h` high during cycle 2.
- Miss latency: 4 + N cycles, where N is the number of MWAIT cycles before `mem_ack_h`. With ack in the first MWAIT cycle, `rd_done_h` is high during cycle 5.
- `busy_h` = (state != IDLE).
- Reset asserted mid-fill or mid-flush aborts immediately: no write strobe after reset asserts, and the flush index returns to 0.

## Test plan
- Reset, then hit: `rd_req_h`, `pa_h` = 24'h012344, `ca_hit_h` = 1 in LOOKUP, `cache_out_h` = 32'hDEADBEEF -> `rd_done_h` at cycle 2, `rd_data_h` = DEADBEEF, no `mem_req_h`.
- Miss: `ca_hit_h` = 0, ack after 3 wait cycles with 32'h12345678 -> `mem_addr_h` = 012344; one `cache_grp0_wr_h` cycle with `cache_valid_0_h` = 1 and `ena_byte_l` = 0; `rd_done_h` at cycle 7.
- Parity: hit with `ca_data_par_err_l` = 0 -> memory read performed, `ca_perr_h` = 1 and stays set through later reads.
- Memory error: `mem_err_h` = 1 with ack -> fill with `cache_valid_0_h` = 0, `rd_err_h` = 1 alongside `rd_done_h`.
- Flush: `flush_req_h` in IDLE -> 1024 consecutive write cycles, `pad_h[11:2]` from 0 to 3FF, valid = 0; `busy_h` low the cycle after; a `rd_req_h` held during the flush starts after it.
- Collision: `flush_req_h` during MWAIT -> read completes first, then flush begins; reset asserted at flush index 200 -> outputs return to reset values immediately.

Source files
------------

// File: rtl/cache_fill_ctl.sv
// Cache read/fill sequencer: looks up a read, refills from memory on a miss or parity error,
// and sweeps every cache index with tag-only invalidate writes on a flush request.
module cache_fill_ctl #(
   parameter int unsigned FLUSH_LINES = 1024
) (
   input  logic        b_clk_l,
   input  logic        reset_h,
   input  logic        rd_req_h,
   input  logic [23:0] pa_h,
   input  logic        flush_req_h,
   input  logic        ca_hit_h,
   input  logic        ca_tag_par_err_h,
   input  logic        ca_data_par_err_l,
   input  logic [31:0] cache_out_h,
   input  logic        mem_ack_h,
   input  logic        mem_err_h,
   input  logic [31:0] mem_data_h,
   output logic [23:0] pad_h,
   output logic [31:0] cache_h,
   output logic        cache_grp0_wr_h,
   output logic        cache_valid_0_h,
   output logic [3:0]  ena_byte_l,
   output logic        ca_hit_inh_h,
   output logic        mem_req_h,
   output logic [23:0] mem_addr_h,
   output logic [31:0] rd_data_h,
   output logic        rd_done_h,
   output logic        rd_err_h,
   output logic        busy_h,
   output logic        ca_perr_h
);

   localparam logic [9:0] LastIdx = 10'(FLUSH_LINES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StMreq,
      StMwait,
      StFill,
      StFlush
   } state_e;

   state_e      state_q, state_d;
   logic [23:0] addr_q, addr_d;
   logic [31:0] mdata_q, mdata_d;
   logic        merr_q, merr_d;
   logic [9:0]  idx_q, idx_d;
   logic        pend_q, pend_d;
   logic        perr_q, perr_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_done_q, rd_done_d;
   logic        rd_err_q, rd_err_d;
   logic        par_err;

   assign par_err = ca_tag_par_err_h | ~ca_data_par_err_l;

   always_ff @(posedge b_clk_l or posedge reset_h) begin
      if (reset_h) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         mdata_q   <= '0;
         merr_q    <= 1'b0;
         idx_q     <= '0;
         pend_q    <= 1'b0;
         perr_q    <= 1'b0;
         rd_data_q <= '0;
         rd_done_q <= 1'b0;
         rd_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         mdata_q   <= mdata_d;
         merr_q    <= merr_d;
         idx_q     <= idx_d;
         pend_q    <= pend_d;
         perr_q    <= perr_d;
         rd_data_q <= rd_data_d;
         rd_done_q <= rd_done_d;
         rd_err_q  <= rd_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      mdata_d   = mdata_q;
      merr_d    = merr_q;
      idx_d     = idx_q;
      pend_d    = pend_q;
      perr_d    = perr_q;
      rd_data_d = rd_data_q;
      rd_done_d = 1'b0;
      rd_err_d  = 1'b0;

      // A flush arriving mid-read waits for the read to finish.
      if (flush_req_h && (state_q inside {StLookup, StMreq, StMwait, StFill})) begin
         pend_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (flush_req_h || pend_q) begin
               state_d = StFlush;
               idx_d   = '0;
               pend_d  = 1'b0;
            end else if (rd_req_h) begin
               addr_d  = pa_h;
               state_d = StLookup;
            end
         end
         StLookup: begin
            if (par_err) begin
               perr_d = 1'b1;
            end
            if (ca_hit_h && !par_err) begin
               rd_data_d = cache_out_h;
               rd_done_d = 1'b1;
               state_d   = StIdle;
            end else begin
               state_d = StMreq;
            end
         end
         StMreq: begin
            state_d = StMwait;
         end
         StMwait: begin
            if (mem_ack_h) begin
               mdata_d = mem_data_h;
               merr_d  = mem_err_h;
               state_d = StFill;
            end
         end
         StFill: begin
            rd_data_d = mdata_q;
            rd_err_d  = merr_q;
            rd_done_d = 1'b1;
            state_d   = StIdle;
         end
         StFlush: begin
            if (idx_q == LastIdx) begin
               idx_d   = '0;
               state_d = StIdle;
            end else begin
               idx_d = idx_q + 10'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      pad_h           = addr_q;
      cache_h         = mdata_q;
      cache_grp0_wr_h = 1'b0;
      cache_valid_0_h = 1'b0;
      ena_byte_l      = 4'b1111;
      if (state_q == StFlush) begin
         pad_h           = {12'h000, idx_q, 2'b00};
         cache_grp0_wr_h = 1'b1;
      end else if (state_q == StFill) begin
         cache_grp0_wr_h = 1'b1;
         cache_valid_0_h = ~merr_q;
         ena_byte_l      = 4'b0000;
      end
   end

   // Request drops combinationally in the ack cycle.
   assign mem_req_h    = (state_q == StMreq) | ((state_q == StMwait) & ~mem_ack_h);
   assign mem_addr_h   = addr_q;
   assign ca_hit_inh_h = (state_q != StLookup);
   assign busy_h       = (state_q != StIdle);
   assign rd_data_h    = rd_data_q;
   assign rd_done_h    = rd_done_q;
   assign rd_err_h     = rd_err_q;
   assign ca_perr_h    = perr_q;

endmodule

// File: tb/tb_cache_fill_ctl.sv
// Randomized bench for cache_fill_ctl: expected latencies, data and flush sweeps come from
// the block's stated timing rules, not from its state machine.
module tb_cache_fill_ctl;

   logic        b_clk_l = 1'b0;
   logic        reset_h;
   logic        rd_req_h;
   logic [23:0] pa_h;
   logic        flush_req_h;
   logic        ca_hit_h;
   logic        ca_tag_par_err_h;
   logic        ca_data_par_err_l;
   logic [31:0] cache_out_h;
   logic        mem_ack_h;
   logic        mem_err_h;
   logic [31:0] mem_data_h;
   logic [23:0] pad_h;
   logic [31:0] cache_h;
   logic        cache_grp0_wr_h;
   logic        cache_valid_0_h;
   logic [3:0]  ena_byte_l;
   logic        ca_hit_inh_h;
   logic        mem_req_h;
   logic [23:0] mem_addr_h;
   logic [31:0] rd_data_h;
   logic        rd_done_h;
   logic        rd_err_h;
   logic        busy_h;
   logic        ca_perr_h;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        perr_exp;

   always #5 b_clk_l = ~b_clk_l;

   cache_fill_ctl #(.FLUSH_LINES(1024)) dut (
      .b_clk_l           (b_clk_l),
      .reset_h           (reset_h),
      .rd_req_h          (rd_req_h),
      .pa_h              (pa_h),
      .flush_req_h       (flush_req_h),
      .ca_hit_h          (ca_hit_h),
      .ca_tag_par_err_h  (ca_tag_par_err_h),
      .ca_data_par_err_l (ca_data_par_err_l),
      .cache_out_h       (cache_out_h),
      .mem_ack_h         (mem_ack_h),
      .mem_err_h         (mem_err_h),
      .mem_data_h        (mem_data_h),
      .pad_h             (pad_h),
      .cache_h           (cache_h),
      .cache_grp0_wr_h   (cache_grp0_wr_h),
      .cache_valid_0_h   (cache_valid_0_h),
      .ena_byte_l        (ena_byte_l),
      .ca_hit_inh_h      (ca_hit_inh_h),
      .mem_req_h         (mem_req_h),
      .mem_addr_h        (mem_addr_h),
      .rd_data_h         (rd_data_h),
      .rd_done_h         (rd_done_h),
      .rd_err_h          (rd_err_h),
      .busy_h            (busy_h),
      .ca_perr_h         (ca_perr_h)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Step to just after the rising edge and put junk on inputs the block should ignore.
   task automatic next_cycle();
      @(posedge b_clk_l);
      #1;
      rd_req_h          = 1'b0;
      flush_req_h       = 1'b0;
      mem_ack_h         = 1'b0;
      pa_h              = 24'($urandom);
      ca_hit_h          = 1'($urandom);
      ca_tag_par_err_h  = 1'($urandom);
      ca_data_par_err_l = 1'($urandom);
      cache_out_h       = $urandom;
      mem_err_h         = 1'($urandom);
      mem_data_h        = $urandom;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr"}, 32'(cache_grp0_wr_h), 32'd0);
      check({tag, "_ena"}, 32'(ena_byte_l), 32'hF);
      check({tag, "_inh"}, 32'(ca_hit_inh_h), 32'd1);
      check({tag, "_busy"}, 32'(busy_h), 32'd0);
      check({tag, "_pad"}, 32'(pad_h), 32'd0);
      check({tag, "_memreq"}, 32'(mem_req_h), 32'd0);
      check({tag, "_done"}, 32'(rd_done_h), 32'd0);
      check({tag, "_perr"}, 32'(ca_perr_h), 32'd0);
   endtask

   task automatic read_start(input logic [23:0] addr);
      next_cycle();
      rd_req_h = 1'b1;
      pa_h     = addr;
      settle();
      check("start_idle", 32'(busy_h), 32'd0);
   endtask

   // Cycle 1 is the lookup; hit done at cycle 2, miss done at cycle 4+nwait.
   task automatic read_rest(input logic [23:0] addr, input logic hit, input logic tperr,
                            input logic dperr_l, input logic [31:0] cout, input int nwait,
                            input logic merr, input logic [31:0] mdata, input bit flush_mid);
      bit          miss;
      int          last;
      int          done_at;
      int          req_cycles;
      int          wr_cycles;
      int          bad;
      logic [31:0] got_data;
      logic        got_err;
      miss = !hit || tperr || !dperr_l;
      if (tperr || !dperr_l) perr_exp = 1'b1;
      last       = miss ? 4 + nwait : 2;
      done_at    = -1;
      req_cycles = 0;
      wr_cycles  = 0;
      bad        = 0;
      got_data   = '0;
      got_err    = 1'b0;

      next_cycle();
      ca_hit_h          = hit;
      ca_tag_par_err_h  = tperr;
      ca_data_par_err_l = dperr_l;
      cache_out_h       = cout;
      settle();
      check("lookup_inh", 32'(ca_hit_inh_h), 32'd0);
      check("lookup_pad", 32'(pad_h), 32'(addr));

      for (int c = 2; c <= last; c++) begin
         next_cycle();
         if (miss && c == 2 + nwait) begin
            mem_ack_h  = 1'b1;
            mem_err_h  = merr;
            mem_data_h = mdata;
         end
         if (flush_mid && miss && c == 3) flush_req_h = 1'b1;
         settle();
         if (mem_req_h) begin
            req_cycles++;
            if (mem_addr_h !== addr) bad++;
         end
         if (cache_grp0_wr_h) begin
            wr_cycles++;
            if (c != 3 + nwait || cache_h !== mdata || cache_valid_0_h !== !merr ||
                ena_byte_l !== 4'b0000) bad++;
         end
         if (rd_done_h && done_at < 0) begin
            done_at  = c;
            got_data = rd_data_h;
            got_err  = rd_err_h;
         end
      end
      check("done_cycle", 32'(done_at), 32'(last));
      check("rd_data", got_data, miss ? mdata : cout);
      check("rd_err", 32'(got_err), miss ? 32'(merr) : 32'd0);
      check("mem_req_cycles", 32'(req_cycles), miss ? 32'(nwait) : 32'd0);
      check("fill_writes", 32'(wr_cycles), miss ? 32'd1 : 32'd0);
      check("fill_fields", 32'(bad), 32'd0);
      check("done_not_busy", 32'(busy_h), 32'd0);
      check("perr_sticky", 32'(ca_perr_h), 32'(perr_exp));
   endtask

   task automatic flush_body(input bit hold, input logic [23:0] addr);
      int bad;
      int wr;
      bad = 0;
      wr  = 0;
      for (int i = 0; i < 1024; i++) begin
         next_cycle();
         if (hold) begin
            rd_req_h = 1'b1;
            pa_h     = addr;
         end
         settle();
         if (cache_grp0_wr_h) wr++;
         if (!cache_grp0_wr_h || cache_valid_0_h || ena_byte_l !== 4'hF || !busy_h ||
             pad_h !== {12'h000, 10'(i), 2'b00}) bad++;
      end
      check("flush_writes", 32'(wr), 32'd1024);
      check("flush_fields", 32'(bad), 32'd0);
      next_cycle();
      if (hold) begin
         rd_req_h = 1'b1;
         pa_h     = addr;
      end
      settle();
      check("flush_end_busy", 32'(busy_h), 32'd0);
      check("flush_end_wr", 32'(cache_grp0_wr_h), 32'd0);
   endtask

   task automatic flush_start(input bit hold, input logic [23:0] addr);
      next_cycle();
      flush_req_h = 1'b1;
      if (hold) begin
         rd_req_h = 1'b1;
         pa_h     = addr;
      end
      settle();
   endtask

   initial begin
      logic [23:0] a;
      int          bad;
      reset_h           = 1'b1;
      rd_req_h          = 1'b0;
      pa_h              = '0;
      flush_req_h       = 1'b0;
      ca_hit_h          = 1'b0;
      ca_tag_par_err_h  = 1'b0;
      ca_data_par_err_l = 1'b1;
      cache_out_h       = '0;
      mem_ack_h         = 1'b0;
      mem_err_h         = 1'b0;
      mem_data_h        = '0;
      perr_exp          = 1'b0;
      repeat (3) @(posedge b_clk_l);
      #4;
      check_reset_outputs("reset");
      check("reset_rd_data", rd_data_h, 32'd0);
      @(posedge b_clk_l);
      #1;
      reset_h = 1'b0;

      // Directed hit, miss, parity and memory-error reads.
      read_start(24'h012344);
      read_rest(24'h012344, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1, 1'b0, 32'h0, 1'b0);
      read_start(24'h012344);
      read_rest(24'h012344, 1'b0, 1'b0, 1'b1, 32'h0BADF00D, 3, 1'b0, 32'h12345678, 1'b0);
      read_start(24'hABCDE0);
      read_rest(24'hABCDE0, 1'b1, 1'b0, 1'b0, 32'h11112222, 2, 1'b0, 32'h33334444, 1'b0);
      read_start(24'h000100);
      read_rest(24'h000100, 1'b0, 1'b0, 1'b1, 32'h0, 1, 1'b1, 32'hCAFEF00D, 1'b0);

      for (int n = 0; n < 30; n++) begin
         a = 24'($urandom);
         read_start(a);
         read_rest(a, 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                   $urandom, $urandom_range(1, 6), $urandom_range(0, 3) == 0, $urandom, 1'b0);
      end

      // Plain flush, then a flush with a read held through it.
      flush_start(1'b0, 24'h0);
      flush_body(1'b0, 24'h0);
      a = 24'h5A5A54;
      flush_start(1'b1, a);
      flush_body(1'b1, a);
      read_rest(a, 1'b1, 1'b0, 1'b1, 32'h76543210, 1, 1'b0, 32'h0, 1'b0);

      // Flush requested during the memory wait runs right after the read.
      read_start(24'h0FF000);
      read_rest(24'h0FF000, 1'b0, 1'b0, 1'b1, 32'h0, 4, 1'b0, 32'hA5A5A5A5, 1'b1);
      flush_body(1'b0, 24'h0);

      // Reset at flush index 200 aborts the sweep immediately.
      flush_start(1'b0, 24'h0);
      bad = 0;
      for (int i = 0; i <= 200; i++) begin
         next_cycle();
         settle();
         if (pad_h !== {12'h000, 10'(i), 2'b00} || !cache_grp0_wr_h) bad++;
      end
      check("pre_reset_sweep", 32'(bad), 32'd0);
      #1;
      reset_h = 1'b1;
      #1;
      perr_exp = 1'b0;
      check_reset_outputs("midflush_reset");
      next_cycle();
      reset_h = 1'b0;
      settle();
      check("post_reset_idle", 32'(busy_h), 32'd0);
      flush_start(1'b0, 24'h0);
      flush_body(1'b0, 24'h0);
      read_start(24'h123458);
      read_rest(24'h123458, 1'b1, 1'b0, 1'b1, 32'h0F0F0F0F, 1, 1'b0, 32'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
